// File: rtl/gba_audio_pkg.sv
// rtl/gba_audio_pkg.sv - shared GBA audio types, constants and sample expansion helper
// Purpose: common definitions for the Direct Sound FIFO channel and mixer.
// Contents: ds_sample_t (signed 8-bit FIFO sample), audio_wave_t (24-bit mixer word),
//           DS_FIFO_BYTES / DS_REQ_LEVEL defaults, ds_expand() sample widening.
package gba_audio_pkg;

  typedef logic signed [7:0] ds_sample_t;
  typedef logic [23:0]       audio_wave_t;

  localparam int DS_FIFO_BYTES = 32;
  localparam int DS_REQ_LEVEL  = 16;

  // Sign-extend to 24 bits first, then shift; bits shifted past bit 23 are lost.
  function automatic audio_wave_t ds_expand(input ds_sample_t s, input int unsigned shift);
    audio_wave_t ext;
    ext = {{16{s[7]}}, s};
    return ext << shift;
  endfunction

endpackage

// File: rtl/ds_fifo_mem.sv
// rtl/ds_fifo_mem.sv - FIFO_BYTES x 8 storage with 32-bit word write and byte read
// Purpose: sample storage for one Direct Sound channel.
// Ports:
//   clock    in   system clock
//   we_i     in   write strobe, stores all four bytes of wdata_i
//   waddr_i  in   word address (byte address / 4)
//   wdata_i  in   four samples, bits 7:0 land at the lowest byte address
//   raddr_i  in   byte address to read
//   rdata_o  out  combinational read of the addressed byte
module ds_fifo_mem
  import gba_audio_pkg::*;
#(
  parameter int FIFO_BYTES = DS_FIFO_BYTES
) (
  input  logic                            clock,
  input  logic                            we_i,
  input  logic [$clog2(FIFO_BYTES)-3:0]   waddr_i,
  input  logic [31:0]                     wdata_i,
  input  logic [$clog2(FIFO_BYTES)-1:0]   raddr_i,
  output ds_sample_t                      rdata_o
);

  logic [7:0] mem_q [FIFO_BYTES];

  // Storage carries no reset: contents are only ever read behind the count.
  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[{waddr_i, 2'(i)}] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = ds_sample_t'(mem_q[raddr_i]);

endmodule

// File: rtl/ds_fifo_channel.sv
// rtl/ds_fifo_channel.sv - one Direct Sound channel: word FIFO, timer-paced pop, DMA request
// Purpose: buffers CPU/DMA words, plays one signed byte per selected timer overflow,
//          and requests a refill when the FIFO drains to REQ_LEVEL bytes.
// Optional feature: define DS_FIFO_OVERRUN_FLAG_EN to add the sticky 'overrun' output.
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-low reset
//   fifo_wr     in   push strobe for fifo_wdata (4 samples, byte 0 first)
//   fifo_wdata  in   32-bit sample word
//   timer0_ovf  in   timer 0 overflow pulse
//   timer1_ovf  in   timer 1 overflow pulse
//   timer_num   in   selects which timer paces playback
//   fifo_reset  in   level clear from the mixer
//   sample_out  out  current sample, sign-extended and shifted, 24 bits
//   dma_req     out  one-cycle refill request
//   fifo_count  out  bytes held
//   overrun     out  sticky drop/underrun flag (DS_FIFO_OVERRUN_FLAG_EN only)
module ds_fifo_channel
  import gba_audio_pkg::*;
#(
  parameter int FIFO_BYTES   = DS_FIFO_BYTES,
  parameter int REQ_LEVEL    = DS_REQ_LEVEL,
  parameter int SAMPLE_SHIFT = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          fifo_wr,
  input  logic [31:0]                   fifo_wdata,
  input  logic                          timer0_ovf,
  input  logic                          timer1_ovf,
  input  logic                          timer_num,
  input  logic                          fifo_reset,
  output audio_wave_t                   sample_out,
  output logic                          dma_req,
`ifdef DS_FIFO_OVERRUN_FLAG_EN
  output logic                          overrun,
`endif
  output logic [$clog2(FIFO_BYTES):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_BYTES);
  localparam int CW = AW + 1;

  logic [AW-3:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  audio_wave_t   sample_q, sample_d;
  logic          dma_q, dma_d;
  logic          fifo_reset_q;

  logic       tick, full, empty, push, pop;
  ds_sample_t rd_byte;

  assign tick  = timer_num ? timer1_ovf : timer0_ovf;
  // Full/empty come from the pre-cycle count, so a same-cycle pop never sees the pushed word.
  assign full  = count_q > CW'(FIFO_BYTES - 4);
  assign empty = count_q == '0;
  assign push  = fifo_wr && !full;
  assign pop   = tick && !empty;

  ds_fifo_mem #(.FIFO_BYTES(FIFO_BYTES)) u_mem (
    .clock   (clock),
    .we_i    (push && !fifo_reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (fifo_wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_byte)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sample_d = sample_q;
    dma_d    = 1'b0;
    if (fifo_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      sample_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        sample_d = ds_expand(rd_byte, SAMPLE_SHIFT);
      end
      count_d = count_q + (push ? CW'(4) : CW'(0)) - (pop ? CW'(1) : CW'(0));
      // Crossing down to REQ_LEVEL, or the first cycle after a clear (FIFO now empty).
      dma_d = (pop && !push && count_q == CW'(REQ_LEVEL + 1)) || fifo_reset_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sample_q     <= '0;
      dma_q        <= 1'b0;
      fifo_reset_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sample_q     <= sample_d;
      dma_q        <= dma_d;
      fifo_reset_q <= fifo_reset;
    end
  end

`ifdef DS_FIFO_OVERRUN_FLAG_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (fifo_reset) overrun_d = 1'b0;
    else if ((fifo_wr && full) || (tick && empty)) overrun_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

  assign sample_out = sample_q;
  // A request registered just before fifo_reset rises is masked while the clear is held.
  assign dma_req    = dma_q && !fifo_reset;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_ds_fifo_channel.sv
// tb/tb_ds_fifo_channel.sv - directed self-checking bench for ds_fifo_channel
module tb_ds_fifo_channel;
  import gba_audio_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fifo_wr = 1'b0;
  logic [31:0] fifo_wdata = '0;
  logic        timer0_ovf = 1'b0;
  logic        timer1_ovf = 1'b0;
  logic        timer_num = 1'b0;
  logic        fifo_reset = 1'b0;
  audio_wave_t sample_out;
  logic        dma_req;
  logic [5:0]  fifo_count;
`ifdef DS_FIFO_OVERRUN_FLAG_EN
  logic        overrun;
`endif

  int total = 0;
  int bad   = 0;

  ds_fifo_channel dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .timer0_ovf (timer0_ovf),
    .timer1_ovf (timer1_ovf),
    .timer_num  (timer_num),
    .fifo_reset (fifo_reset),
    .sample_out (sample_out),
    .dma_req    (dma_req),
`ifdef DS_FIFO_OVERRUN_FLAG_EN
    .overrun    (overrun),
`endif
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w);
    fifo_wr = 1'b1;
    fifo_wdata = w;
    step();
    fifo_wr = 1'b0;
  endtask

  task automatic tick0();
    timer0_ovf = 1'b1;
    step();
    timer0_ovf = 1'b0;
  endtask

  task automatic tick1();
    timer1_ovf = 1'b1;
    step();
    timer1_ovf = 1'b0;
  endtask

  logic [31:0] exp_s [4];
  int          dma_hits;

  initial begin
    exp_s[0] = 32'hFFFF00; exp_s[1] = 32'h000200;
    exp_s[2] = 32'h000300; exp_s[3] = 32'h000400;

    // Reset state
    #2;
    chk("reset_sample", sample_out, 0);
    chk("reset_count", fifo_count, 0);
    chk("reset_dma", dma_req, 0);
    step();
    reset = 1'b1;
    step();

    // Basic pop order and sign extension
    write_word(32'h040302FF);
    chk("t1_count_wr", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      tick0();
      chk($sformatf("t1_sample%0d", i), sample_out, exp_s[i]);
      chk($sformatf("t1_count%0d", i), fifo_count, 32'(3 - i));
    end

    // Fill, overrun drop, drain with single DMA request at 16
    for (int k = 0; k < 8; k++) begin
      if (k == 7) write_word(32'h051E1D1C);
      else write_word({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end
    chk("t2_full_count", fifo_count, 32);
    write_word(32'hAAAAAAAA);
    chk("t2_drop_count", fifo_count, 32);
    dma_hits = 0;
    for (int i = 0; i < 32; i++) begin
      tick0();
      chk($sformatf("t2_dma%0d", i), dma_req, (i == 15) ? 1 : 0);
      if (dma_req) dma_hits++;
      chk($sformatf("t2_sample%0d", i), sample_out, (i == 31) ? 32'h000500 : 32'(i << 8));
    end
    chk("t2_dma_hits", dma_hits, 1);
    chk("t2_empty", fifo_count, 0);

    // Underrun holds sample
    tick0();
    chk("t3_hold_sample", sample_out, 32'h000500);
    chk("t3_hold_count", fifo_count, 0);
`ifdef DS_FIFO_OVERRUN_FLAG_EN
    chk("t3_overrun", overrun, 1);
`endif

    // Timer select and simultaneous push/pop
    timer_num = 1'b1;
    write_word(32'h14131211);
    write_word(32'h18171615);
    tick0();
    chk("t4_ign_count", fifo_count, 8);
    chk("t4_ign_sample", sample_out, 32'h000500);
    tick1();
    chk("t4_pop1", sample_out, 32'h001100);
    tick1();
    chk("t4_pop2", sample_out, 32'h001200);
    tick1();
    chk("t4_pop3", sample_out, 32'h001300);
    chk("t4_count5", fifo_count, 5);
    fifo_wr = 1'b1; fifo_wdata = 32'h1C1B1A19; timer1_ovf = 1'b1;
    step();
    fifo_wr = 1'b0; timer1_ovf = 1'b0;
    chk("t4_both_count", fifo_count, 8);
    chk("t4_both_sample", sample_out, 32'h001400);

    // fifo_reset overrides push and pop, then requests refill
    write_word(32'h201F1E1D);
    chk("t5_count12", fifo_count, 12);
    fifo_reset = 1'b1; fifo_wr = 1'b1; fifo_wdata = 32'h7F7F7F7F; timer1_ovf = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("t5_clr_count%0d", i), fifo_count, 0);
      chk($sformatf("t5_clr_sample%0d", i), sample_out, 0);
      chk($sformatf("t5_clr_dma%0d", i), dma_req, 0);
    end
`ifdef DS_FIFO_OVERRUN_FLAG_EN
    chk("t5_overrun_clr", overrun, 0);
`endif
    fifo_reset = 1'b0; fifo_wr = 1'b0; timer1_ovf = 1'b0;
    step();
    chk("t5_dma_pulse", dma_req, 1);
    step();
    chk("t5_dma_end", dma_req, 0);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 5; k++) write_word(32'h04030201);
    tick1();
    write_word(32'h08070605);
    chk("t6_count", fifo_count, 23);
    chk("t6_sample", sample_out, 32'h000100);
    reset = 1'b0;
    #1;
    chk("t6_async_count", fifo_count, 0);
    chk("t6_async_sample", sample_out, 0);
    chk("t6_async_dma", dma_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
